// File: rtl/text_console_writer.sv
// Byte stream to character memory writer with cursor, control codes
// and screen/line blanking for the text video path.
module text_console_writer #(
  parameter int COLS = 80,
  parameter int ROWS = 30
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        vc_write_enable,
  output logic [7:0]  vc_char_in,
  output logic [12:0] vid_ch_addr,
  output logic [6:0]  cursor_col,
  output logic [4:0]  cursor_row,
  output logic        busy
);

  typedef enum logic [1:0] {
    CLR_SCREEN,
    IDLE,
    CLR_LINE
  } state_t;

  localparam logic [12:0] SCR_LAST  = 13'(COLS * ROWS - 1);
  localparam logic [12:0] LINE_LAST = 13'(COLS - 1);
  localparam logic [12:0] COLS13    = 13'(COLS);
  localparam logic [6:0]  COL_LAST  = 7'(COLS - 1);
  localparam logic [4:0]  ROW_LAST  = 5'(ROWS - 1);
  localparam logic [7:0]  SPACE     = 8'h20;

  state_t      state_q, state_d;
  logic [12:0] cnt_q, cnt_d;
  logic [6:0]  col_q, col_d;
  logic [4:0]  row_q, row_d;
  logic        we_q, we_d;
  logic [7:0]  char_q, char_d;
  logic [12:0] addr_q, addr_d;

  logic [12:0] row_base;
  logic [12:0] cur_addr;
  logic [4:0]  next_row;
  logic        printable;

  assign row_base  = 13'(row_q) * COLS13;
  assign cur_addr  = row_base + 13'(col_q);
  assign next_row  = (row_q == ROW_LAST) ? 5'd0 : row_q + 5'd1;
  assign printable = (in_data >= 8'h20) && (in_data <= 8'h7E);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    col_d   = col_q;
    row_d   = row_q;
    we_d    = 1'b0;
    char_d  = char_q;
    addr_d  = addr_q;
    unique case (state_q)
      CLR_SCREEN: begin
        we_d   = 1'b1;
        char_d = SPACE;
        addr_d = cnt_q;
        cnt_d  = cnt_q + 13'd1;
        if (cnt_q == SCR_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
          col_d   = '0;
          row_d   = '0;
        end
      end
      CLR_LINE: begin
        we_d   = 1'b1;
        char_d = SPACE;
        addr_d = row_base + cnt_q;
        cnt_d  = cnt_q + 13'd1;
        if (cnt_q == LINE_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      IDLE: begin
        if (in_valid) begin
          unique case (1'b1)
            printable: begin
              we_d   = 1'b1;
              char_d = in_data;
              addr_d = cur_addr;
              if (col_q == COL_LAST) begin
                col_d   = '0;
                row_d   = next_row;
                state_d = CLR_LINE;
              end else begin
                col_d = col_q + 7'd1;
              end
            end
            (in_data == 8'h0A): begin
              col_d   = '0;
              row_d   = next_row;
              state_d = CLR_LINE;
            end
            (in_data == 8'h0D): col_d = '0;
            (in_data == 8'h08): begin
              if (col_q != 7'd0) begin
                col_d  = col_q - 7'd1;
                we_d   = 1'b1;
                char_d = SPACE;
                addr_d = cur_addr - 13'd1;
              end
            end
            (in_data == 8'h0C): state_d = CLR_SCREEN;
            default: ;
          endcase
        end
      end
      default: begin
        state_d = CLR_SCREEN;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLR_SCREEN;
      cnt_q   <= '0;
      col_q   <= '0;
      row_q   <= '0;
      we_q    <= 1'b0;
      char_q  <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      col_q   <= col_d;
      row_q   <= row_d;
      we_q    <= we_d;
      char_q  <= char_d;
      addr_q  <= addr_d;
    end
  end

  assign in_ready        = (state_q == IDLE);
  assign busy            = (state_q != IDLE);
  assign vc_write_enable = we_q;
  assign vc_char_in      = char_q;
  assign vid_ch_addr     = addr_q;
  assign cursor_col      = col_q;
  assign cursor_row      = row_q;

endmodule

// File: tb/tb_text_console_writer.sv
// Directed bench for text_console_writer with a 4x3 screen.
module tb_text_console_writer;

  logic        clk;
  logic        rst_n;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        vc_write_enable;
  logic [7:0]  vc_char_in;
  logic [12:0] vid_ch_addr;
  logic [6:0]  cursor_col;
  logic [4:0]  cursor_row;
  logic        busy;

  int n_chk;
  int n_fail;

  text_console_writer #(.COLS(4), .ROWS(3)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_data         (in_data),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .vc_write_enable (vc_write_enable),
    .vc_char_in      (vc_char_in),
    .vid_ch_addr     (vid_ch_addr),
    .cursor_col      (cursor_col),
    .cursor_row      (cursor_row),
    .busy            (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    in_data  = b;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    #12;
    n_chk++;
    if (vc_write_enable !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b1 ||
        vid_ch_addr !== 13'd0 || vc_char_in !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_vals: we=%b rdy=%b busy=%b addr=%0d ch=%h want 0 0 1 0 00",
               vc_write_enable, in_ready, busy, vid_ch_addr, vc_char_in);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      n_chk++;
      if (vc_write_enable !== 1'b1 || vid_ch_addr !== 13'(i) ||
          vc_char_in !== 8'h20 || in_ready !== (i == 11)) begin
        n_fail++;
        $display("FAIL reset_clear[%0d]: we=%b addr=%0d ch=%h rdy=%b want 1 %0d 20 %b",
                 i, vc_write_enable, vid_ch_addr, vc_char_in, in_ready, i, i == 11);
      end
    end
    n_chk++;
    if (cursor_col !== 7'd0 || cursor_row !== 5'd0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_cursor: col=%0d row=%0d busy=%b want 0 0 0",
               cursor_col, cursor_row, busy);
    end
    step();
    n_chk++;
    if (vc_write_enable !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle_we: we=%b want 0", vc_write_enable);
    end
  endtask

  task automatic test_text_lf();
    send(8'h41);
    n_chk++;
    if (vc_write_enable !== 1'b1 || vc_char_in !== 8'h41 || vid_ch_addr !== 13'd0 ||
        cursor_col !== 7'd1) begin
      n_fail++;
      $display("FAIL write_A: we=%b ch=%h addr=%0d col=%0d want 1 41 0 1",
               vc_write_enable, vc_char_in, vid_ch_addr, cursor_col);
    end
    send(8'h42);
    n_chk++;
    if (vc_write_enable !== 1'b1 || vc_char_in !== 8'h42 || vid_ch_addr !== 13'd1 ||
        cursor_col !== 7'd2) begin
      n_fail++;
      $display("FAIL write_B: we=%b ch=%h addr=%0d col=%0d want 1 42 1 2",
               vc_write_enable, vc_char_in, vid_ch_addr, cursor_col);
    end
    send(8'h0A);
    n_chk++;
    if (vc_write_enable !== 1'b0 || cursor_col !== 7'd0 || cursor_row !== 5'd1 ||
        in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL lf: we=%b col=%0d row=%0d rdy=%b want 0 0 1 0",
               vc_write_enable, cursor_col, cursor_row, in_ready);
    end
    for (int k = 1; k <= 4; k++) begin
      step();
      n_chk++;
      if (vc_write_enable !== 1'b1 || vid_ch_addr !== 13'(3 + k) ||
          vc_char_in !== 8'h20 || in_ready !== (k == 4)) begin
        n_fail++;
        $display("FAIL lf_clear[%0d]: we=%b addr=%0d ch=%h rdy=%b want 1 %0d 20 %b",
                 k, vc_write_enable, vid_ch_addr, vc_char_in, in_ready, 3 + k, k == 4);
      end
    end
  endtask

  task automatic test_back_to_back_wrap();
    logic [7:0] s [4];
    s = '{8'h57, 8'h58, 8'h59, 8'h5A};
    send(8'h0A);
    for (int k = 0; k < 4; k++) step();
    n_chk++;
    if (cursor_row !== 5'd2 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL to_row2: row=%0d rdy=%b want 2 1", cursor_row, in_ready);
    end
    for (int i = 0; i < 4; i++) begin
      send(s[i]);
      n_chk++;
      if (vc_write_enable !== 1'b1 || vc_char_in !== s[i] || vid_ch_addr !== 13'(8 + i)) begin
        n_fail++;
        $display("FAIL wrap_write[%0d]: we=%b ch=%h addr=%0d want 1 %h %0d",
                 i, vc_write_enable, vc_char_in, vid_ch_addr, s[i], 8 + i);
      end
    end
    n_chk++;
    if (cursor_col !== 7'd0 || cursor_row !== 5'd0 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_cursor: col=%0d row=%0d rdy=%b want 0 0 0",
               cursor_col, cursor_row, in_ready);
    end
    for (int k = 1; k <= 4; k++) begin
      step();
      n_chk++;
      if (vc_write_enable !== 1'b1 || vid_ch_addr !== 13'(k - 1) || vc_char_in !== 8'h20) begin
        n_fail++;
        $display("FAIL wrap_clear[%0d]: we=%b addr=%0d ch=%h want 1 %0d 20",
                 k, vc_write_enable, vid_ch_addr, vc_char_in, k - 1);
      end
    end
  endtask

  task automatic test_backspace();
    send(8'h0A);
    for (int k = 0; k < 4; k++) step();
    send(8'h61);
    send(8'h62);
    n_chk++;
    if (cursor_col !== 7'd2 || cursor_row !== 5'd1) begin
      n_fail++;
      $display("FAIL bs_setup: col=%0d row=%0d want 2 1", cursor_col, cursor_row);
    end
    send(8'h08);
    n_chk++;
    if (vc_write_enable !== 1'b1 || vc_char_in !== 8'h20 || vid_ch_addr !== 13'd5 ||
        cursor_col !== 7'd1 || cursor_row !== 5'd1) begin
      n_fail++;
      $display("FAIL bs_mid: we=%b ch=%h addr=%0d col=%0d row=%0d want 1 20 5 1 1",
               vc_write_enable, vc_char_in, vid_ch_addr, cursor_col, cursor_row);
    end
    send(8'h0D);
    send(8'h08);
    n_chk++;
    if (vc_write_enable !== 1'b0 || cursor_col !== 7'd0 || cursor_row !== 5'd1) begin
      n_fail++;
      $display("FAIL bs_col0: we=%b col=%0d row=%0d want 0 0 1",
               vc_write_enable, cursor_col, cursor_row);
    end
  endtask

  task automatic test_ignore_ff();
    logic [7:0] q [3];
    q = '{8'h0D, 8'h07, 8'h7F};
    send(8'h63);
    n_chk++;
    if (vc_write_enable !== 1'b1 || vid_ch_addr !== 13'd4 || cursor_col !== 7'd1) begin
      n_fail++;
      $display("FAIL ign_setup: we=%b addr=%0d col=%0d want 1 4 1",
               vc_write_enable, vid_ch_addr, cursor_col);
    end
    for (int i = 0; i < 3; i++) begin
      send(q[i]);
      n_chk++;
      if (vc_write_enable !== 1'b0 || cursor_col !== 7'd0 || cursor_row !== 5'd1 ||
          in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL ignore[%h]: we=%b col=%0d row=%0d rdy=%b want 0 0 1 1",
                 q[i], vc_write_enable, cursor_col, cursor_row, in_ready);
      end
    end
    send(8'h0C);
    n_chk++;
    if (vc_write_enable !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL ff_entry: we=%b rdy=%b busy=%b want 0 0 1",
               vc_write_enable, in_ready, busy);
    end
    for (int k = 1; k <= 12; k++) begin
      step();
      n_chk++;
      if (vc_write_enable !== 1'b1 || vid_ch_addr !== 13'(k - 1) ||
          vc_char_in !== 8'h20 || in_ready !== (k == 12)) begin
        n_fail++;
        $display("FAIL ff_clear[%0d]: we=%b addr=%0d ch=%h rdy=%b want 1 %0d 20 %b",
                 k, vc_write_enable, vid_ch_addr, vc_char_in, in_ready, k - 1, k == 12);
      end
    end
    n_chk++;
    if (cursor_col !== 7'd0 || cursor_row !== 5'd0) begin
      n_fail++;
      $display("FAIL ff_cursor: col=%0d row=%0d want 0 0", cursor_col, cursor_row);
    end
  endtask

  task automatic test_reset_midclear();
    send(8'h64);
    send(8'h0A);
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (vc_write_enable !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b1 ||
        cursor_col !== 7'd0 || cursor_row !== 5'd0 || vid_ch_addr !== 13'd0) begin
      n_fail++;
      $display("FAIL midclear_rst: we=%b rdy=%b busy=%b col=%0d row=%0d addr=%0d want 0 0 1 0 0 0",
               vc_write_enable, in_ready, busy, cursor_col, cursor_row, vid_ch_addr);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      n_chk++;
      if (vc_write_enable !== 1'b1 || vid_ch_addr !== 13'(i) || in_ready !== (i == 11)) begin
        n_fail++;
        $display("FAIL midclear_restart[%0d]: we=%b addr=%0d rdy=%b want 1 %0d %b",
                 i, vc_write_enable, vid_ch_addr, in_ready, i, i == 11);
      end
    end
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    test_reset();
    test_text_lf();
    test_back_to_back_wrap();
    test_backspace();
    test_ignore_ff();
    test_reset_midclear();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
